// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: RV32IM IF stage with PC, imem handshake, one-entry stall buffer and IF/ID register.
// Optional FETCH_COUNT/BUBBLE_COUNT ports are enabled by defining IFETCH_PERF_COUNTERS_EN.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic [31:0] IMEM_ADDRESS,
   output logic        IMEM_READ,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] PC_ID,
   output logic [31:0] PC_PLUS4_ID,
   output logic        VALID_ID,
   output logic        FETCH_STALL
`ifdef IFETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] FETCH_COUNT,
   output logic [31:0] BUBBLE_COUNT
`endif
);
   typedef enum logic [1:0] {START, FETCH, DISCARD} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, redirect_pc_q, redirect_pc_d;
   logic [31:0] instr_q, instr_d, pc_id_q, pc_id_d, pc4_id_q, pc4_id_d;
   logic        valid_q, valid_d;
   logic        buf_full_q, buf_full_d;
   logic [31:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;
   logic        load, bubble, complete;
   logic [31:0] pc_plus4, target;
   assign pc_plus4     = pc_q + 32'd4;
   assign target       = {BRANCH_TARGET[31:2], 2'b00};
   assign IMEM_ADDRESS = pc_q;
   assign IMEM_READ    = (state_q == FETCH && !buf_full_q) || state_q == DISCARD;
   assign complete     = IMEM_READ && !IMEM_BUSYWAIT;
   assign FETCH_STALL  = (IMEM_READ && IMEM_BUSYWAIT) || state_q == DISCARD;
   assign INSTRUCTION  = instr_q;
   assign PC_ID        = pc_id_q;
   assign PC_PLUS4_ID  = pc4_id_q;
   assign VALID_ID     = valid_q;
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      redirect_pc_d = redirect_pc_q;
      buf_full_d    = buf_full_q;
      buf_instr_d   = buf_instr_q;
      buf_pc_d      = buf_pc_q;
      instr_d       = instr_q;
      pc_id_d       = pc_id_q;
      pc4_id_d      = pc4_id_q;
      valid_d       = valid_q;
      load          = 1'b0;
      bubble        = 1'b0;
      case (state_q)
         START: begin
            state_d = FETCH;
            if (BRANCH_TAKEN) begin
               pc_d   = target;
               bubble = 1'b1;
            end
         end
         FETCH: begin
            if (BRANCH_TAKEN) begin
               bubble     = 1'b1;
               buf_full_d = 1'b0;
               // A busy access cannot be cancelled; let it finish in DISCARD
               if (IMEM_READ && IMEM_BUSYWAIT) begin
                  redirect_pc_d = target;
                  state_d       = DISCARD;
               end else begin
                  pc_d = target;
               end
            end else if (STALL) begin
               if (complete) begin
                  buf_full_d  = 1'b1;
                  buf_instr_d = IMEM_READDATA;
                  buf_pc_d    = pc_q;
                  pc_d        = pc_plus4;
               end
            end else if (buf_full_q) begin
               load       = 1'b1;
               instr_d    = buf_instr_q;
               pc_id_d    = buf_pc_q;
               pc4_id_d   = buf_pc_q + 32'd4;
               valid_d    = 1'b1;
               buf_full_d = 1'b0;
            end else if (complete) begin
               load     = 1'b1;
               instr_d  = IMEM_READDATA;
               pc_id_d  = pc_q;
               pc4_id_d = pc_plus4;
               valid_d  = 1'b1;
               pc_d     = pc_plus4;
            end else begin
               bubble = 1'b1;
            end
         end
         DISCARD: begin
            redirect_pc_d = BRANCH_TAKEN ? target : redirect_pc_q;
            if (complete) begin
               pc_d    = BRANCH_TAKEN ? target : redirect_pc_q;
               state_d = FETCH;
            end
            bubble = BRANCH_TAKEN || !STALL;
         end
         default: state_d = START;
      endcase
      if (bubble) begin
         load    = 1'b1;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q       <= START;
         pc_q          <= RESET_PC;
         redirect_pc_q <= 32'd0;
         buf_full_q    <= 1'b0;
         buf_instr_q   <= NOP_INSTR;
         buf_pc_q      <= 32'd0;
         instr_q       <= NOP_INSTR;
         pc_id_q       <= 32'd0;
         pc4_id_q      <= 32'd0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         redirect_pc_q <= redirect_pc_d;
         buf_full_q    <= buf_full_d;
         buf_instr_q   <= buf_instr_d;
         buf_pc_q      <= buf_pc_d;
         if (load) begin
            instr_q  <= instr_d;
            pc_id_q  <= pc_id_d;
            pc4_id_q <= pc4_id_d;
            valid_q  <= valid_d;
         end
      end
   end
`ifdef IFETCH_PERF_COUNTERS_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q + {31'd0, load && valid_d};
      bubble_cnt_d = bubble_cnt_q + {31'd0, load && !valid_d};
   end
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         fetch_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end
   assign FETCH_COUNT  = fetch_cnt_q;
   assign BUBBLE_COUNT = bubble_cnt_q;
`endif
endmodule
